// File: rtl/risc_br_pkg.sv
// Shared definitions for the branch unit: branch opcode encodings,
// controller state type and the taken-decision helper.
package risc_br_pkg;

    typedef enum logic [1:0] {
        BR_BEQZ  = 2'b00,
        BR_BNEQZ = 2'b01,
        BR_JUMP  = 2'b10,
        BR_RSVD  = 2'b11
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EVAL   = 2'b01,
        ST_UPDATE = 2'b10
    } br_state_e;

    // Branch decision from the opcode and the operand zero flag.
    // The reserved opcode never redirects fetch.
    function automatic logic br_taken(input br_op_e op, input logic eq);
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQZ:  t = eq;
            BR_BNEQZ: t = ~eq;
            BR_JUMP:  t = 1'b1;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/br_stat_cnt.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module br_stat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Increment on enable unless already saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit. A request is latched in IDLE, the zero flag is
// sampled one cycle later in EVAL, and UPDATE issues the registered fetch
// PC together with the pc_load / flush strobes. One branch per 3 cycles.
// Optional statistics counters (br_count, taken_count) are built when the
// macro BRANCH_STATS_EN is defined.
module branch_unit
    import risc_br_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_op,
    input  logic [31:0]      br_offset,
    input  logic [31:0]      npc_in,
    input  logic             eq,
    output logic [31:0]      pc_out,
    output logic             pc_load,
    output logic             taken,
    output logic             flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
`endif
);

    br_state_e   state;
    br_op_e      op_q;
    logic [31:0] offset_q;
    logic [31:0] npc_q;
    logic [31:0] target_q;
    logic        taken_q;

    // The unit accepts a new request only while idle.
    assign br_ready = (state == ST_IDLE);

    // Controller: latch request, evaluate, then publish the fetch PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= BR_BEQZ;
            offset_q <= '0;
            npc_q    <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            pc_out   <= RESET_PC;
            pc_load  <= 1'b0;
            taken    <= 1'b0;
            flush    <= 1'b0;
        end else begin
            // Strobes last exactly one cycle after leaving UPDATE.
            pc_load <= 1'b0;
            flush   <= 1'b0;
            taken   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        op_q     <= br_op_e'(br_op);
                        offset_q <= br_offset;
                        npc_q    <= npc_in;
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // Operand zero flag has settled by now; target wraps mod 2^32.
                    taken_q  <= br_taken(op_q, eq);
                    target_q <= npc_q + offset_q;
                    state    <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    pc_out  <= taken_q ? target_q : npc_q;
                    pc_load <= 1'b1;
                    flush   <= taken_q;
                    taken   <= taken_q;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic upd_en;
    logic upd_taken_en;

    // Count every resolved branch, and separately the taken ones.
    assign upd_en       = (state == ST_UPDATE);
    assign upd_taken_en = upd_en & taken_q;

    br_stat_cnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_en),
        .count (br_count)
    );

    br_stat_cnt #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_taken_en),
        .count (taken_count)
    );
`endif

endmodule
